// File: rtl/leitor_teclas_if.sv
// leitor_teclas_if: switch-decoder inputs, consumer pop and key-event queue outputs
interface leitor_teclas_if #(
    parameter int FIFO_DEPTH = 4
);
    logic [3:0]                      tecla;
    logic                            ready;
    logic                            pop;
    logic                            key_valid;
    logic [3:0]                      key_out;
    logic [$clog2(FIFO_DEPTH+1)-1:0] count;
    logic                            overflow;
    logic [15:0]                     LEDR;
    modport master (
        output tecla, ready, pop,
        input  key_valid, key_out, count, overflow, LEDR
    );
    modport slave (
        input  tecla, ready, pop,
        output key_valid, key_out, count, overflow, LEDR
    );
endinterface

// File: rtl/leitor_teclas.sv
// leitor_teclas: debounced switch-key reader with one event per press, show-ahead queue and LED echo
module leitor_teclas #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input logic           clk,
    input logic           reset,
    leitor_teclas_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int NW = $clog2(DEBOUNCE_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;
    state_t        state_q;
    logic [3:0]    tecla_q;
    logic          ready_q;
    logic [3:0]    cand_q;
    logic [NW-1:0] cnt_q;
    logic [15:0]   led_q;
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          last, acc, full, do_pop, do_push;
    // register the raw switch inputs once so the FSM never sees them combinationally
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            tecla_q <= '0;
        end else begin
            ready_q <= bus.ready;
            tecla_q <= bus.tecla;
        end
    end
    // accept fires on the edge that completes the stable run of the candidate key
    always_comb begin
        last    = cnt_q == NW'(DEBOUNCE_CYCLES - 1);
        acc     = state_q == CONFIRM && ready_q && tecla_q == cand_q && last;
        full    = count_q == CW'(FIFO_DEPTH);
        do_pop  = bus.pop && count_q != '0;
        do_push = acc && (!full || do_pop);
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        ovf_d   = ovf_q || (acc && full && !do_pop);
    end
    // press/release debounce FSM; LED echo is updated on every accepted press, even if dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            led_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (ready_q) begin
                    state_q <= CONFIRM;
                    cand_q  <= tecla_q;
                    cnt_q   <= NW'(1);
                end
                CONFIRM: if (!ready_q) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else if (tecla_q != cand_q) begin
                    cand_q <= tecla_q;
                    cnt_q  <= NW'(1);
                end else if (last) begin
                    state_q <= HELD;
                    cnt_q   <= '0;
                    led_q   <= 16'(1) << cand_q;
                end else begin
                    cnt_q <= cnt_q + NW'(1);
                end
                HELD: if (!ready_q) begin
                    state_q <= RELEASE;
                    cnt_q   <= NW'(1);
                end
                RELEASE: if (ready_q) begin
                    state_q <= HELD;
                    cnt_q   <= '0;
                end else if (last) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + NW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    // queue pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end
    // queue storage needs no reset: key_out is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= cand_q;
    end
    assign bus.key_valid = count_q != '0;
    assign bus.key_out   = count_q != '0 ? mem_q[rd_q] : 4'd0;
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;
    assign bus.LEDR      = led_q;
endmodule

// File: tb/tb_leitor_teclas.sv
// tb_leitor_teclas: directed vectors, corner sequences and random stimulus against a run-length model
module tb_leitor_teclas;
    localparam int DB = 4;
    localparam int FD = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    leitor_teclas_if #(.FIFO_DEPTH(FD)) bus();
    leitor_teclas #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(FD)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    typedef struct {
        logic        rs;
        logic        rd;
        logic [3:0]  tk;
        logic        pp;
        logic        v;
        logic [3:0]  k;
        int          c;
        logic        o;
        logic [15:0] led;
    } vec_t;
    vec_t vec [23];
    logic bs [13] = '{1, 1, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0};
    int total = 0;
    int bad = 0;
    int q[$];
    logic        m_ovf = 0, m_held = 0, pr = 0;
    logic [3:0]  pt = 0, rkey = 0;
    logic [15:0] m_led = 0;
    int          run = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic step(input logic rs, input logic r, input logic [3:0] t, input logic p);
        logic acc, pe, full;
        reset = rs;
        bus.ready = r;
        bus.tecla = t;
        bus.pop = p;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ovf = 0; m_led = 0; m_held = 0; run = 0; pr = 0; pt = 0; rkey = 0;
        end else begin
            acc = 0;
            if (!m_held) begin
                if (pr) begin
                    run = (run > 0 && pt == rkey) ? run + 1 : 1;
                    rkey = pt;
                    if (run == DB) begin
                        acc = 1; m_held = 1; run = 0;
                    end
                end else run = 0;
            end else begin
                run = pr ? 0 : run + 1;
                if (run == DB) begin
                    m_held = 0; run = 0;
                end
            end
            pe = p && q.size() > 0;
            full = q.size() == FD;
            if (pe) void'(q.pop_front());
            if (acc) begin
                m_led = 16'(1) << rkey;
                if (full && !pe) m_ovf = 1;
                else q.push_back(int'(rkey));
            end
            pr = r;
            pt = t;
        end
        #1;
        chk("valid", bus.key_valid, q.size() > 0);
        chk("key_out", bus.key_out, q.size() > 0 ? q[0] : 0);
        chk("count", bus.count, q.size());
        chk("overflow", bus.overflow, m_ovf);
        chk("LEDR", bus.LEDR, m_led);
    endtask
    task automatic press(input logic [3:0] k, input int pop_at);
        for (int j = 0; j < 12; j++) step(0, j < 6, k, j == pop_at);
    endtask
    initial begin
        logic rr;
        logic [3:0] tt;
        rr = 0;
        tt = 0;
        bus.tecla = 0;
        bus.ready = 0;
        bus.pop = 0;
        for (int i = 0; i < 23; i++) begin
            vec[i].rs  = i < 2;
            vec[i].rd  = i >= 2 && i < 12;
            vec[i].tk  = 4'd9;
            vec[i].pp  = i == 22;
            vec[i].v   = i >= 6 && i < 22;
            vec[i].k   = vec[i].v ? 4'd9 : 4'd0;
            vec[i].c   = vec[i].v ? 1 : 0;
            vec[i].o   = 0;
            vec[i].led = i >= 6 ? 16'h0200 : 16'h0000;
        end
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0);
            chk("idle_valid", bus.key_valid, 0);
            chk("idle_LEDR", bus.LEDR, 0);
        end
        for (int i = 0; i < 23; i++) begin
            step(vec[i].rs, vec[i].rd, vec[i].tk, vec[i].pp);
            chk("t_valid", bus.key_valid, vec[i].v);
            chk("t_key", bus.key_out, vec[i].k);
            chk("t_count", bus.count, vec[i].c);
            chk("t_ovf", bus.overflow, vec[i].o);
            chk("t_LEDR", bus.LEDR, vec[i].led);
        end
        for (int i = 0; i < 13; i++) begin
            step(0, bs[i], 3, 0);
            if (i == 6) chk("bounce_early", bus.count, 0);
            if (i == 7) chk("bounce_event", bus.count, 1);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 3, 0);
        chk("bounce_count", bus.count, 1);
        chk("bounce_key", bus.key_out, 3);
        step(0, 0, 0, 1);
        chk("bounce_empty", bus.key_valid, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int k = 1; k <= 5; k++) press(4'(k), -1);
        chk("ovf_count", bus.count, 4);
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_LEDR", bus.LEDR, 16'h0020);
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_pop_key", bus.key_out, k);
            step(0, 0, 0, 1);
        end
        chk("ovf_drained", bus.key_valid, 0);
        step(1, 0, 0, 0);
        for (int k = 1; k <= 4; k++) press(4'(k), -1);
        press(7, 4);
        chk("pp_count", bus.count, 4);
        chk("pp_ovf", bus.overflow, 0);
        for (int k = 0; k < 4; k++) begin
            chk("pp_pop_key", bus.key_out, k < 3 ? k + 2 : 7);
            step(0, 0, 0, 1);
        end
        chk("pp_drained", bus.key_valid, 0);
        step(1, 0, 0, 0);
        step(0, 1, 6, 0);
        step(0, 1, 6, 0);
        step(1, 1, 6, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 6, 0);
            chk("rst_LEDR", bus.LEDR, i < 4 ? 16'h0000 : 16'h0040);
            chk("rst_valid", bus.key_valid, i >= 4);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 12) rr = ~rr;
            if ($urandom_range(0, 99) < 8) tt = 4'($urandom);
            step($urandom_range(0, 599) == 0, rr, tt, $urandom_range(0, 99) < 20);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
